// File: rtl/if_id_ctrl_pkg.sv
// Shared types and constants for the IF/ID front-end flow controller.
package if_id_ctrl_pkg;

  localparam int unsigned PC_W_DEF = 32;
  localparam int unsigned PERF_W   = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/if_id_ostd_cnt.sv
// Saturating up/down counter of in-flight fetches with registered full/zero flags.
module if_id_ostd_cnt #(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt_nxt_c,
  output logic         full,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Simultaneous inc/dec cancels; the guards keep the count inside [0, MAX].
  always_comb begin
    cnt_nxt_c = cnt;
    if (inc && !dec && !full) begin
      cnt_nxt_c = cnt + W'(1);
    end else if (dec && !inc && !zero) begin
      cnt_nxt_c = cnt - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      full <= 1'b0;
      zero <= 1'b1;
    end else begin
      cnt  <= cnt_nxt_c;
      full <= (cnt_nxt_c == W'(MAX));
      zero <= (cnt_nxt_c == '0);
    end
  end

endmodule

// File: rtl/if_id_ctrl.sv
// IFU -> IF/ID flow controller: fetch tracking, redirect squash/drain, new-PC handoff.
// Optional perf counters are built when IF_ID_CTRL_PERF_EN is defined.
module if_id_ctrl
  import if_id_ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned MAX_OSTD = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              f_req_en_o,
  input  logic              f_req_fire_i,
  input  logic              f_valid_i,
  output logic              f_ready_o,
  output logic              p_valid_o,
  input  logic              p_ready_i,
  input  logic              redir_valid_i,
  input  logic [PC_W-1:0]   redir_pc_i,
  output logic              flush_o,
  output logic              redir_valid_o,
  output logic [PC_W-1:0]   redir_pc_o,
  output logic [PERF_W-1:0] perf_flush_o,
  output logic [PERF_W-1:0] perf_drain_o
);

  localparam int unsigned OSTD_W = $clog2(MAX_OSTD + 1);

  state_e            state;
  state_e            state_nxt;
  logic [OSTD_W-1:0] cnt_nxt;
  logic              cnt_full;
  logic              cnt_zero;
  logic              acc;
  logic              handoff;
  logic [PC_W-1:0]   pc_lat;

  if_id_ostd_cnt #(
    .MAX (MAX_OSTD),
    .W   (OSTD_W)
  ) u_ostd_cnt (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .inc       (f_req_fire_i),
    .dec       (acc),
    .cnt_nxt_c (cnt_nxt),
    .full      (cnt_full),
    .zero      (cnt_zero)
  );

  assign f_req_en_o = (state == ST_RUN) & ~redir_valid_i & ~cnt_full;
  assign acc        = f_valid_i & f_ready_o;

  // Handshake mux: pass-through only in RUN without a redirect, otherwise discard.
  always_comb begin
    f_ready_o = 1'b1;
    p_valid_o = 1'b0;
    if (!redir_valid_i && (state == ST_RUN)) begin
      f_ready_o = p_ready_i;
      p_valid_o = f_valid_i;
    end
  end

  // Next state; a redirect in any state restarts the squash sequence.
  always_comb begin
    state_nxt = state;
    handoff   = 1'b0;
    if (redir_valid_i) begin
      state_nxt = (cnt_nxt != '0) ? ST_DRAIN : ST_REDIR;
    end else begin
      case (state)
        ST_RUN:   state_nxt = ST_RUN;
        ST_DRAIN: if (cnt_nxt == '0) state_nxt = ST_REDIR;
        ST_REDIR: begin
          state_nxt = ST_RUN;
          handoff   = 1'b1;
        end
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= ST_RUN;
      pc_lat        <= '0;
      flush_o       <= 1'b0;
      redir_valid_o <= 1'b0;
      redir_pc_o    <= '0;
    end else begin
      state         <= state_nxt;
      flush_o       <= redir_valid_i;
      redir_valid_o <= handoff;
      if (redir_valid_i) pc_lat <= redir_pc_i;
      if (handoff) redir_pc_o <= pc_lat;
    end
  end

`ifdef IF_ID_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_flush_q;
  logic [PERF_W-1:0] perf_drain_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_flush_q <= '0;
      perf_drain_q <= '0;
    end else begin
      if (redir_valid_i) perf_flush_q <= perf_flush_q + PERF_W'(1);
      if (state == ST_DRAIN) perf_drain_q <= perf_drain_q + PERF_W'(1);
    end
  end

  assign perf_flush_o = perf_flush_q;
  assign perf_drain_o = perf_drain_q;
`else
  assign perf_flush_o = '0;
  assign perf_drain_o = '0;
`endif

`ifndef SYNTHESIS
  a_no_rsp_at_zero: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(f_valid_i && cnt_zero));
  a_fire_legal: assert property (@(posedge clk_i) disable iff (!rst_i)
    f_req_fire_i |-> f_req_en_o);
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Self-checking bench for if_id_ctrl: vector table, directed redirect sequences,
// and randomized traffic against a cycle-level reference model.
module tb_if_id_ctrl;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned MAX_OSTD = 2;
`ifdef IF_ID_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            f_req_en_o;
  logic            f_req_fire_i;
  logic            f_valid_i;
  logic            f_ready_o;
  logic            p_valid_o;
  logic            p_ready_i;
  logic            redir_valid_i;
  logic [PC_W-1:0] redir_pc_i;
  logic            flush_o;
  logic            redir_valid_o;
  logic [PC_W-1:0] redir_pc_o;
  logic [31:0]     perf_flush_o;
  logic [31:0]     perf_drain_o;

  int n_vec = 0;
  int n_err = 0;

  if_id_ctrl #(.PC_W(PC_W), .MAX_OSTD(MAX_OSTD)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .f_req_en_o    (f_req_en_o),
    .f_req_fire_i  (f_req_fire_i),
    .f_valid_i     (f_valid_i),
    .f_ready_o     (f_ready_o),
    .p_valid_o     (p_valid_o),
    .p_ready_i     (p_ready_i),
    .redir_valid_i (redir_valid_i),
    .redir_pc_i    (redir_pc_i),
    .flush_o       (flush_o),
    .redir_valid_o (redir_valid_o),
    .redir_pc_o    (redir_pc_o),
    .perf_flush_o  (perf_flush_o),
    .perf_drain_o  (perf_drain_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        fire, fv, pr, rv;
    logic [31:0] rpc;
    logic        en, rdy, pv, fl, rvo;
    logic [31:0] rpo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic fire, fv, pr, rv, input logic [31:0] rpc,
                              input logic en, rdy, pv, fl, rvo, input logic [31:0] rpo);
    vec_t v;
    v = '{fire, fv, pr, rv, rpc, en, rdy, pv, fl, rvo, rpo};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, leave outputs 1 time unit to settle.
  task automatic drive(input logic fire, fv, pr, rv, input logic [31:0] rpc);
    @(negedge clk_i);
    f_req_fire_i  = fire;
    f_valid_i     = fv;
    p_ready_i     = pr;
    redir_valid_i = rv;
    redir_pc_i    = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    f_req_fire_i = 0; f_valid_i = 0; p_ready_i = 1; redir_valid_i = 0; redir_pc_i = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Redirect with two fetches in flight; their responses arrive 3 and 5 cycles later.
  task automatic run_drain(input bit check_perf);
    int fl_n = 0, rvo_n = 0, rvo_k = -1;
    logic [31:0] rvo_pc = '0;
    drive(1, 0, 1, 0, '0);
    drive(1, 0, 1, 0, '0);
    drive(0, 0, 1, 1, 32'h8000_0100);
    chk("drain_redir_en", {31'd0, f_req_en_o}, 32'd0);
    chk("drain_redir_rdy", {31'd0, f_ready_o}, 32'd1);
    for (int k = 1; k <= 9; k++) begin
      drive(0, (k == 3 || k == 5), 0, 0, '0);
      chk($sformatf("drain_pv_k%0d", k), {31'd0, p_valid_o}, 32'd0);
      if (k == 3 || k == 5) chk($sformatf("drain_rdy_k%0d", k), {31'd0, f_ready_o}, 32'd1);
      if (k <= 6) chk($sformatf("drain_en_k%0d", k), {31'd0, f_req_en_o}, 32'd0);
      if (flush_o) fl_n++;
      if (redir_valid_o) begin rvo_n++; rvo_k = k; rvo_pc = redir_pc_o; end
    end
    chk("drain_flush_pulses", fl_n, 1);
    chk("drain_redir_pulses", rvo_n, 1);
    // REDIR is entered the cycle after the last response; the pulse is registered out of it.
    chk("drain_redir_cycle", rvo_k, 7);
    chk("drain_redir_pc", rvo_pc, 32'h8000_0100);
    if (check_perf) begin
      chk("perf_flush", perf_flush_o, PERF_ON ? 32'd1 : 32'd0);
      chk("perf_drain", perf_drain_o, PERF_ON ? 32'd5 : 32'd0);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    f_req_fire_i = 0; f_valid_i = 0; p_ready_i = 1; redir_valid_i = 0; redir_pc_i = '0;

    // fire fv pr rv rpc | en rdy pv fl rvo rpo
    // streaming at one request per cycle
    add(1, 0, 1, 0, 0,            1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0,            1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0,            1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0,            1, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,            1, 1, 1, 0, 0, 0);
    // backpressure with two in flight
    add(1, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,            1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,            0, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,            1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,            1, 1, 0, 0, 0, 0);
    // redirect with nothing in flight: flush next cycle, new PC the cycle after
    add(0, 0, 1, 1, 32'h8000_0040, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,            0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0,            1, 1, 0, 0, 1, 32'h8000_0040);
    add(0, 0, 1, 0, 0,            1, 1, 0, 0, 0, 32'h8000_0040);

    // reset values while held in reset
    @(negedge clk_i); @(negedge clk_i); #1;
    chk("rst_flush", {31'd0, flush_o}, 0);
    chk("rst_redir_valid", {31'd0, redir_valid_o}, 0);
    chk("rst_redir_pc", redir_pc_o, 0);
    chk("rst_req_en", {31'd0, f_req_en_o}, 1);
    chk("rst_perf_flush", perf_flush_o, 0);
    chk("rst_perf_drain", perf_drain_o, 0);
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].fire, tbl[i].fv, tbl[i].pr, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("v%0d_en", i),  {31'd0, f_req_en_o},    {31'd0, tbl[i].en});
      chk($sformatf("v%0d_rdy", i), {31'd0, f_ready_o},     {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d_pv", i),  {31'd0, p_valid_o},     {31'd0, tbl[i].pv});
      chk($sformatf("v%0d_fl", i),  {31'd0, flush_o},       {31'd0, tbl[i].fl});
      chk($sformatf("v%0d_rvo", i), {31'd0, redir_valid_o}, {31'd0, tbl[i].rvo});
      chk($sformatf("v%0d_rpo", i), redir_pc_o,             tbl[i].rpo);
    end

    run_drain(1'b0);

    // back-to-back redirects: second arrives while draining
    begin
      int fl_n = 0, rvo_n = 0;
      logic [31:0] rvo_pc = '0;
      drive(1, 0, 1, 0, '0);
      drive(1, 0, 1, 0, '0);
      drive(0, 0, 1, 1, 32'h8000_0100);
      for (int k = 1; k <= 8; k++) begin
        drive(0, (k == 3 || k == 4), 1, (k == 2), 32'h8000_0200);
        chk($sformatf("b2b_pv_k%0d", k), {31'd0, p_valid_o}, 0);
        if (flush_o) fl_n++;
        if (redir_valid_o) begin rvo_n++; rvo_pc = redir_pc_o; end
      end
      chk("b2b_flush_pulses", fl_n, 2);
      chk("b2b_redir_pulses", rvo_n, 1);
      chk("b2b_redir_pc", rvo_pc, 32'h8000_0200);
    end

    // asynchronous reset in DRAIN with one fetch outstanding
    drive(1, 0, 1, 0, '0);
    drive(0, 0, 1, 1, 32'h8000_0300);
    drive(0, 0, 1, 0, '0);
    chk("mid_drain_flush", {31'd0, flush_o}, 1);
    rst_i = 1'b0;
    #1;
    chk("async_rst_flush", {31'd0, flush_o}, 0);
    chk("async_rst_redir_valid", {31'd0, redir_valid_o}, 0);
    chk("async_rst_redir_pc", redir_pc_o, 0);
    chk("async_rst_req_en", {31'd0, f_req_en_o}, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(k == 1, k == 2, 1, 0, '0);
      chk($sformatf("post_rst_en_k%0d", k), {31'd0, f_req_en_o}, 1);
      chk($sformatf("post_rst_rvo_k%0d", k), {31'd0, redir_valid_o}, 0);
      if (k == 2) chk("post_rst_pv", {31'd0, p_valid_o}, 1);
    end

    run_drain(1'b1);

    // randomized traffic against a reference model
    do_reset();
    begin
      int          ost = 0;
      bit          busy = 0, pulse_due = 0, prev_rv = 0;
      logic [31:0] pc_pend = '0, pc_out = '0, pf = '0, pd = '0;
      logic        rv, fire, fv, pr, e_en, e_rdy, e_pv, acc, handoff;
      logic [31:0] rpc;
      for (int n = 0; n < 1500; n++) begin
        rv   = ($urandom_range(0, 11) == 0);
        rpc  = $urandom;
        e_en = !busy && !rv && (ost < MAX_OSTD);
        fire = e_en && ($urandom_range(0, 2) != 0);
        fv   = (ost > 0) && ($urandom_range(0, 1) == 1);
        pr   = ($urandom_range(0, 3) != 0);
        drive(fire, fv, pr, rv, rpc);
        e_rdy = (busy || rv) ? 1'b1 : pr;
        e_pv  = (busy || rv) ? 1'b0 : fv;
        chk($sformatf("rnd%0d_en", n),  {31'd0, f_req_en_o},    {31'd0, e_en});
        chk($sformatf("rnd%0d_rdy", n), {31'd0, f_ready_o},     {31'd0, e_rdy});
        chk($sformatf("rnd%0d_pv", n),  {31'd0, p_valid_o},     {31'd0, e_pv});
        chk($sformatf("rnd%0d_fl", n),  {31'd0, flush_o},       {31'd0, prev_rv});
        chk($sformatf("rnd%0d_rvo", n), {31'd0, redir_valid_o}, {31'd0, pulse_due});
        chk($sformatf("rnd%0d_rpo", n), redir_pc_o, pc_out);
        chk($sformatf("rnd%0d_pf", n),  perf_flush_o, PERF_ON ? pf : 32'd0);
        chk($sformatf("rnd%0d_pd", n),  perf_drain_o, PERF_ON ? pd : 32'd0);
        // a squash sequence hands off once nothing is left in flight and no new redirect arrives
        acc     = fv && e_rdy;
        handoff = busy && !rv && (ost == 0);
        if (busy && ost != 0) pd = pd + 1;
        if (rv) pf = pf + 1;
        ost = ost + int'(fire) - int'(acc);
        pulse_due = handoff;
        if (handoff) begin
          pc_out = pc_pend;
          busy   = 0;
        end
        if (rv) begin
          busy    = 1;
          pc_pend = rpc;
        end
        prev_rv = rv;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
